// File: rtl/wta_dec_pkg.sv
// Shared types and constants for the WTA class decoder: class encoding,
// control FSM states and the bit positions of the two spike groups.
package wta_dec_pkg;

    typedef enum logic [1:0] {
        CLS_A    = 2'd0,
        CLS_B    = 2'd1,
        CLS_NONE = 2'd2
    } cls_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    localparam int GRP_A_LO = 0;
    localparam int GRP_A_HI = 1;
    localparam int GRP_B_LO = 2;
    localparam int GRP_B_HI = 3;

    function automatic logic [1:0] popcount2(input logic [1:0] bits);
        return {1'b0, bits[0]} + {1'b0, bits[1]};
    endfunction

endpackage

// File: rtl/spike_group_counter.sv
// Saturating accumulator of the popcount of one 2-bit spike group, with a
// synchronous clear and a reload that restarts the count from this cycle's spikes.
module spike_group_counter
    import wta_dec_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [1:0]       bits_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] sum_o
);

    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   base, raw;

    // NOTE: every variable written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        base  = load_i ? '0 : {1'b0, cnt_q};
        raw   = base + {{(CNT_W-1){1'b0}}, popcount2(bits_i)};
        sum_o = (raw > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : raw[CNT_W-1:0];
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = sum_o;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update
    // together at the edge regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/wta_class_decoder.sv
// Integrates the WTA spike stream over fixed windows and emits a confirmed
// class label on a valid/ready channel. Optional macro: WTA_DECODER_CONFLICT_EN.
module wta_class_decoder
    import wta_dec_pkg::*;
#(
    parameter int WIN_LEN    = 16,
    parameter int CNT_W      = 5,
    parameter int MIN_SPIKES = 2,
    parameter int CONFIRM    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [3:0]       spike_in,
    output logic             label_valid,
    input  logic             label_ready,
    output logic             label_class,
    output logic [CNT_W-1:0] label_conf,
    output logic             overrun,
    output logic             conflict_err
);

    localparam int WIN_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int STK_W = $clog2(CONFIRM + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
    localparam logic [STK_W-1:0] STK_MAX  = STK_W'(CONFIRM);
    localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_SPIKES);

    state_e           state_q, state_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [STK_W-1:0] streak_q, streak_d;
    cls_e             last_q, last_d;
    cls_e             committed_q, committed_d;
    logic             label_valid_q, label_valid_d;
    logic             label_class_q, label_class_d;
    logic [CNT_W-1:0] label_conf_q, label_conf_d;
    logic             overrun_q, overrun_d;

    logic [1:0]       bits_a, bits_b;
    logic [CNT_W-1:0] cnt_a, cnt_b, sum_a, sum_b;
    logic             win_open, win_end, commit_try, pending;
    cls_e             cand;

`ifdef WTA_DECODER_CONFLICT_EN
    logic mixed, conflict_q;

    // A mixed cycle breaks WTA exclusivity: flag it and drop its spikes.
    assign mixed  = (|spike_in[GRP_A_HI:GRP_A_LO]) && (|spike_in[GRP_B_HI:GRP_B_LO]);
    assign bits_a = mixed ? 2'b00 : spike_in[GRP_A_HI:GRP_A_LO];
    assign bits_b = mixed ? 2'b00 : spike_in[GRP_B_HI:GRP_B_LO];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_q <= 1'b0;
        end else if (enable && mixed) begin
            conflict_q <= 1'b1;
        end
    end

    assign conflict_err = conflict_q;
`else
    assign bits_a       = spike_in[GRP_A_HI:GRP_A_LO];
    assign bits_b       = spike_in[GRP_B_HI:GRP_B_LO];
    assign conflict_err = 1'b0;
`endif

    // First cycle of a window reloads the counters instead of adding.
    assign win_open = (state_q == ST_ACCUM) && (win_cnt_q != '0);
    assign win_end  = enable && (win_cnt_q == WIN_LAST);

    spike_group_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (!enable),
        .load_i (!win_open),
        .en_i   (enable),
        .bits_i (bits_a),
        .cnt_o  (cnt_a),
        .sum_o  (sum_a)
    );

    spike_group_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (!enable),
        .load_i (!win_open),
        .en_i   (enable),
        .bits_i (bits_b),
        .cnt_o  (cnt_b),
        .sum_o  (sum_b)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enable)  state_d = ST_ACCUM;
            ST_ACCUM: if (!enable) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        if (sum_a > sum_b && sum_a >= MIN_CNT) begin
            cand = CLS_A;
        end else if (sum_b > sum_a && sum_b >= MIN_CNT) begin
            cand = CLS_B;
        end else begin
            cand = CLS_NONE;
        end
    end

    always_comb begin
        win_cnt_d     = win_cnt_q;
        streak_d      = streak_q;
        last_d        = last_q;
        committed_d   = committed_q;
        label_valid_d = label_valid_q;
        label_class_d = label_class_q;
        label_conf_d  = label_conf_q;
        overrun_d     = overrun_q;
        commit_try    = 1'b0;
        pending       = label_valid_q && !label_ready;

        if (!enable) begin
            win_cnt_d = '0;
            streak_d  = '0;
            last_d    = CLS_NONE;
        end else if (win_end) begin
            win_cnt_d = '0;
            if (cand == CLS_NONE) begin
                streak_d = '0;
            end else begin
                streak_d = (cand != last_q) ? STK_W'(1) :
                           (streak_q == STK_MAX) ? STK_MAX : streak_q + 1'b1;
                last_d   = cand;
            end
            commit_try = (streak_d == STK_MAX) && (cand != CLS_NONE) && (cand != committed_q);
        end else begin
            win_cnt_d = win_cnt_q + 1'b1;
        end

        if (label_valid_q && label_ready) begin
            label_valid_d = 1'b0;
        end

        // A label still waiting for its consumer wins over a new commit.
        if (commit_try) begin
            if (pending) begin
                overrun_d = 1'b1;
            end else begin
                committed_d   = cand;
                label_valid_d = 1'b1;
                label_class_d = (cand == CLS_B);
                label_conf_d  = (cand == CLS_B) ? sum_b : sum_a;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            win_cnt_q     <= '0;
            streak_q      <= '0;
            last_q        <= CLS_NONE;
            committed_q   <= CLS_NONE;
            label_valid_q <= 1'b0;
            label_class_q <= 1'b0;
            label_conf_q  <= '0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            win_cnt_q     <= win_cnt_d;
            streak_q      <= streak_d;
            last_q        <= last_d;
            committed_q   <= committed_d;
            label_valid_q <= label_valid_d;
            label_class_q <= label_class_d;
            label_conf_q  <= label_conf_d;
            overrun_q     <= overrun_d;
        end
    end

    assign label_valid = label_valid_q;
    assign label_class = label_class_q;
    assign label_conf  = label_conf_q;
    assign overrun     = overrun_q;

    // Registered counts are only observed through sum_a/sum_b.
    logic unused_cnt;
    assign unused_cnt = ^{cnt_a, cnt_b};

endmodule

// File: tb/tb_wta_class_decoder.sv
// Directed bench for wta_class_decoder: expected labels are queued as stimulus
// is driven and compared when the label is accepted on the valid/ready channel.
`timescale 1ns/1ps
module tb_wta_class_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [3:0] spike_in;
    logic       label_valid;
    logic       label_ready;
    logic       label_class;
    logic [4:0] label_conf;
    logic       overrun;
    logic       conflict_err;

    int   checks   = 0;
    int   failures = 0;
    logic seen_valid;

    typedef struct packed {
        logic       cls;
        logic [4:0] conf;
    } label_t;

    label_t exp_q[$];

`ifdef WTA_DECODER_CONFLICT_EN
    localparam logic [4:0] CONF_T6     = 5'd15;
    localparam logic       CONFLICT_T6 = 1'b1;
`else
    localparam logic [4:0] CONF_T6     = 5'd16;
    localparam logic       CONFLICT_T6 = 1'b0;
`endif

    always #5 clk = ~clk;

    wta_class_decoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .spike_in     (spike_in),
        .label_valid  (label_valid),
        .label_ready  (label_ready),
        .label_class  (label_class),
        .label_conf   (label_conf),
        .overrun      (overrun),
        .conflict_err (conflict_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [3:0] s, input int n);
        spike_in = s;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (label_valid === 1'b1) seen_valid = 1'b1;
        end
    endtask

    task automatic do_reset(input string tag);
        rst_n       = 1'b0;
        enable      = 1'b0;
        label_ready = 1'b0;
        spike_in    = 4'b0000;
        exp_q.delete();
        #12;
        check({tag, "_rst_valid"},    32'(label_valid),  32'd0);
        check({tag, "_rst_class"},    32'(label_class),  32'd0);
        check({tag, "_rst_conf"},     32'(label_conf),   32'd0);
        check({tag, "_rst_overrun"},  32'(overrun),      32'd0);
        check({tag, "_rst_conflict"}, 32'(conflict_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        seen_valid = 1'b0;
    endtask

    task automatic take_label(input string tag);
        label_t e;
        check({tag, "_valid"}, 32'(label_valid), 32'd1);
        check({tag, "_sb_depth"}, 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_class"}, 32'(label_class), 32'(e.cls));
            check({tag, "_conf"},  32'(label_conf),  32'(e.conf));
        end
        label_ready = 1'b1;
        @(posedge clk);
        #1;
        label_ready = 1'b0;
        check({tag, "_drop"}, 32'(label_valid), 32'd0);
    endtask

    initial begin
        // 1: steady A stream, label exactly 32 cycles after enable.
        do_reset("t1");
        enable = 1'b1;
        run(4'b0001, 31);
        check("t1_no_early", 32'(seen_valid), 32'd0);
        exp_q.push_back('{cls: 1'b0, conf: 5'd16});
        run(4'b0001, 1);
        take_label("t1");
        seen_valid = 1'b0;
        run(4'b0001, 32);
        check("t1_no_repeat", 32'(seen_valid), 32'd0);

        // 2: alternating A/B gives 8/8 ties every window.
        do_reset("t2");
        enable = 1'b1;
        for (int i = 0; i < 32; i++) begin
            run(4'b0001, 1);
            run(4'b0100, 1);
        end
        check("t2_tie_no_label", 32'(seen_valid), 32'd0);

        // 3: one A spike per window stays below MIN_SPIKES.
        do_reset("t3");
        enable = 1'b1;
        for (int w = 0; w < 4; w++) begin
            run(4'b0001, 1);
            run(4'b0000, 15);
        end
        check("t3_low_no_label", 32'(seen_valid), 32'd0);

        // 4: overrun while A is pending, then a saturated B label.
        do_reset("t4");
        enable = 1'b1;
        run(4'b0001, 32);
        run(4'b1100, 32);
        check("t4_overrun", 32'(overrun), 32'd1);
        check("t4_hold_valid", 32'(label_valid), 32'd1);
        check("t4_hold_class", 32'(label_class), 32'd0);
        check("t4_hold_conf", 32'(label_conf), 32'd16);
        exp_q.push_back('{cls: 1'b0, conf: 5'd16});
        take_label("t4a");
        run(4'b1100, 31);
        exp_q.push_back('{cls: 1'b1, conf: 5'd31});
        take_label("t4b");
        check("t4_overrun_sticky", 32'(overrun), 32'd1);

        // 5: enable gap inside window 2 clears the streak.
        do_reset("t5");
        enable = 1'b1;
        run(4'b0001, 21);
        enable = 1'b0;
        run(4'b0001, 3);
        enable = 1'b1;
        run(4'b0001, 31);
        check("t5_no_early", 32'(seen_valid), 32'd0);
        exp_q.push_back('{cls: 1'b0, conf: 5'd16});
        run(4'b0001, 1);
        take_label("t5");

        // 6: one mixed-group cycle inside the committing window.
        do_reset("t6");
        enable = 1'b1;
        run(4'b0001, 21);
        run(4'b0101, 1);
        check("t6_conflict", 32'(conflict_err), 32'(CONFLICT_T6));
        run(4'b0001, 10);
        exp_q.push_back('{cls: 1'b0, conf: CONF_T6});
        take_label("t6");
        check("t6_conflict_sticky", 32'(conflict_err), 32'(CONFLICT_T6));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
